fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
- System-clock sequencer between the SPI shift interface and the FFT core.
- Collects one frame of audio samples as 128-bit SPI words and writes them into the FFT sample memory.
- Starts the FFT and waits for completion.
- Reads the coefficients back, packs them into 128-bit words, and presents each word to the SPI interface using the `load`/`done` handshake the MCU already uses.

Parameters:
- N_POINTS, 32, FFT length; power of 2, multiple of 8.
- SAMPLE_W, 16, bits per real sample and per re/im coefficient half.
- WORD_W, 128, SPI word width; equals 8*SAMPLE_W.
- ADDR_W, $clog2(N_POINTS), memory address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  MCU load pin, asynchronous to clk; high during an SPI transaction.
- rx_word  in  WORD_W  word shifted in by spi; stable whenever load is low.
- tx_word  out  WORD_W  coefficient word to spi.
- done  out  1  tx_word valid; spi shifts it out on the next transaction.
- mem_we  out  1  sample write strobe.
- mem_addr  out  ADDR_W  sample write address / coefficient read address.
- mem_wdata  out  SAMPLE_W  sample data.
- mem_rdata  in  2*SAMPLE_W  coefficient {re,im}; valid 1 cycle after address.
- fft_start  out  1  one-cycle start pulse.
- fft_done  in  1  FFT complete pulse or level.
- busy  out  1  high in every state except COLLECT.

Behaviour:
- Reset values: all outputs 0; state COLLECT; word_cnt 0; sample/coef index 0.
- `load` passes through a 2-flop synchronizer.
- load_fall = synced previous 1 and synced current 0. It is detected 3 clk edges after the pin falls.
- COLLECT:
  - On load_fall, capture rx_word into a holding register, then go to WRITE.
- WRITE (8 cycles):
  - Cycle k: mem_we=1, mem_addr = word_cnt*8+k, mem_wdata = hold[WORD_W-1-SAMPLE_W*k -: SAMPLE_W]. This is MSB-first, matching shift order.
  - After k=7: word_cnt++.
  - If word_cnt wraps to N_POINTS/8, clear word_cnt and go to START; else return to COLLECT.
- START:
  - fft_start=1 for exactly 1 cycle, then WAIT_FFT.
- WAIT_FFT:
  - Wait for fft_done=1, then go to READ.
  - fft_done in any other state is ignored.
- READ:
  - Issue 4 consecutive addresses word_cnt*4+j.
  - Capture mem_rdata one cycle later into tx_word[WORD_W-1-2*SAMPLE_W*j -: 2*SAMPLE_W].
  - Takes 5 cycles, then PRESENT.
- PRESENT:
  - done=1; tx_word held constant.
  - On load_fall (MCU finished shifting the word out): done=0 the next cycle and word_cnt++.
  - If word_cnt reaches N_POINTS/4, clear it and go to COLLECT (frame complete); else go to READ.
- During PRESENT, rx_word contents are discarded.
- load_fall in WRITE, START, WAIT_FFT or READ is ignored; that SPI word is lost.
- A load rise is never acted on; only falling edges advance the sequence.
- tx_word retains its last value after done drops.
- reset_n asserted mid-frame immediately returns every output and counter to reset values. The partially written frame is abandoned.

Optional Feature:
- Macro: FFT_FRAME_CTRL_OVERRUN_EN.
- Defined:
  - Adds output `overrun` (1 bit).
  - overrun sets on any load_fall ignored in WRITE, START, WAIT_FFT or READ.
  - It is sticky until reset_n.
  - The state sequence is unchanged.
- Undefined: no port; ignored edges are silent.

Decomposition:
- Package fft_frame_pkg holds:
  - state enum: COLLECT, WRITE, START, WAIT_FFT, READ, PRESENT.
  - SAMPLES_PER_WORD=8, COEFS_PER_WORD=4.
  - IN_WORDS = N_POINTS/8, OUT_WORDS = N_POINTS/4, as functions of N_POINTS.
- Sub-module sync_fall_detect: 2-flop synchronizer plus falling-edge pulse; reset_n clears both flops to 0.

Test Plan:
- Reset: hold reset_n=0 with load toggling -> all outputs 0, busy=0, no mem_we.
- Input frame:
  - Stimulus: 4 load pulses with rx_word word w = samples {16'(8w+0) ... 16'(8w+7)} MSB-first.
  - Required: 32 writes, address i gets data i.
  - Required: exactly one fft_start pulse after the 4th word and none before.
- Output frame:
  - Stimulus: fft_done=1 with model memory rdata[a] = {a, ~a}.
  - Required: 8 PRESENT phases; word w = {rdata[4w], ..., rdata[4w+3]}.
  - Required: done drops 1 cycle after each load_fall is detected; after the 8th, busy=0.
- Overrun: load pulse during WAIT_FFT -> no extra write, state remains WAIT_FFT, overrun=1 (macro defined).
- Reset mid-frame: reset_n low during READ of word 3 -> done=0, word_cnt=0; the next load pulse writes addresses 0-7.
- Ignored fft_done: fft_done=1 during COLLECT -> no transition, no READ activity.

Source files
------------

// File: rtl/fft_frame_pkg.sv
// fft_frame_pkg: shared state encoding and frame geometry for fft_frame_ctrl
package fft_frame_pkg;
    typedef enum logic [2:0] {COLLECT, WRITE, START, WAIT_FFT, READ, PRESENT} state_t;
    localparam int SAMPLES_PER_WORD = 8;
    localparam int COEFS_PER_WORD = 4;
    function automatic int in_words(input int n_points);
        return n_points / SAMPLES_PER_WORD;
    endfunction
    function automatic int out_words(input int n_points);
        return n_points / COEFS_PER_WORD;
    endfunction
endpackage

// File: rtl/fft_frame_ctrl_sync_fall_detect.sv
// sync_fall_detect: 2-flop synchronizer with a one-cycle falling-edge pulse
module sync_fall_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic fall
);
    logic s1, s2, prev;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {s1, s2, prev} <= 3'b000;
        else {s1, s2, prev} <= {d, s1, s2};
    assign fall = prev & ~s2;
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: SPI word <-> FFT memory frame sequencer
// Optional sticky `overrun` output when FFT_FRAME_CTRL_OVERRUN_EN is defined.
module fft_frame_ctrl
    import fft_frame_pkg::*;
#(
    parameter int N_POINTS = 32,
    parameter int SAMPLE_W = 16,
    parameter int WORD_W   = 8 * SAMPLE_W,
    parameter int ADDR_W   = $clog2(N_POINTS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [WORD_W-1:0]     rx_word,
    output logic [WORD_W-1:0]     tx_word,
    output logic                  done,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [SAMPLE_W-1:0]   mem_wdata,
    input  logic [2*SAMPLE_W-1:0] mem_rdata,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic                  busy
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
    ,output logic                 overrun
`endif
);
    localparam int IN_WORDS  = in_words(N_POINTS);
    localparam int OUT_WORDS = out_words(N_POINTS);
    localparam int WC_W      = $clog2(OUT_WORDS) + 1;

    state_t            state, state_nx;
    logic              load_fall, in_last, out_last;
    logic [WC_W-1:0]   word_cnt;
    logic [2:0]        sub;
    logic [WORD_W-1:0] hold;

    sync_fall_detect u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (load),
        .fall    (load_fall)
    );

    assign in_last  = word_cnt == WC_W'(IN_WORDS - 1);
    assign out_last = word_cnt == WC_W'(OUT_WORDS - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= COLLECT;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT:  state_nx = load_fall ? WRITE : COLLECT;
            WRITE:    state_nx = sub != 3'd7 ? WRITE : in_last ? START : COLLECT;
            START:    state_nx = WAIT_FFT;
            WAIT_FFT: state_nx = fft_done ? READ : WAIT_FFT;
            READ:     state_nx = sub == 3'd4 ? PRESENT : READ;
            PRESENT:  state_nx = !load_fall ? PRESENT : out_last ? COLLECT : READ;
            default:  state_nx = COLLECT;
        endcase
    end

    // Read addresses go out in sub 0..3; sub 4 only drains the last read.
    always_comb begin
        busy      = state != COLLECT;
        fft_start = state == START;
        done      = state == PRESENT;
        mem_we    = state == WRITE;
        mem_wdata = state == WRITE ? hold[WORD_W-1 -: SAMPLE_W] : '0;
        mem_addr  = state == WRITE ? ADDR_W'({word_cnt, sub}) :
                    (state == READ && sub != 3'd4) ? ADDR_W'({word_cnt, sub[1:0]}) : '0;
    end

    // hold shifts left so the MSB-first sample is always at the top;
    // tx_word shifts in coefficients so the first read ends up in the top slot.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            word_cnt <= '0;
            sub      <= '0;
            hold     <= '0;
            tx_word  <= '0;
        end else begin
            if (state == COLLECT && load_fall) hold <= rx_word;
            if (state == WRITE) begin
                hold <= hold << SAMPLE_W;
                sub  <= sub + 3'd1;
                if (sub == 3'd7) word_cnt <= in_last ? '0 : word_cnt + 1'b1;
            end
            if (state == READ) begin
                sub <= sub == 3'd4 ? 3'd0 : sub + 3'd1;
                if (sub != 3'd0) tx_word <= {tx_word[WORD_W-2*SAMPLE_W-1:0], mem_rdata};
            end
            if (state == PRESENT && load_fall) word_cnt <= out_last ? '0 : word_cnt + 1'b1;
        end

`ifdef FFT_FRAME_CTRL_OVERRUN_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) overrun <= 1'b0;
        else if (load_fall && state inside {WRITE, START, WAIT_FFT, READ}) overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed/randomized self-checking bench for fft_frame_ctrl
module tb_fft_frame_ctrl;
    logic         clk = 0, reset_n = 0, load = 0, fft_done = 0;
    logic [127:0] rx_word = '0, tx_word;
    logic         done, mem_we, fft_start, busy;
    logic [4:0]   mem_addr;
    logic [15:0]  mem_wdata;
    logic [31:0]  mem_rdata = '0;
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
    logic         overrun;
`endif
    int           total = 0, bad = 0, nstart = 0;
    logic [4:0]   waddr_q[$];
    logic [15:0]  wdata_q[$];
    logic [15:0]  samp[32];

    fft_frame_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .rx_word   (rx_word),
        .tx_word   (tx_word),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .busy      (busy)
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
        ,.overrun  (overrun)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input int a);
        logic [15:0] v;
        v = 16'(a);
        return {v, ~v};
    endfunction

    // FFT coefficient memory: one-cycle read latency
    always @(posedge clk) mem_rdata <= rd(int'(mem_addr));

    always @(negedge clk) begin
        if (mem_we) begin
            waddr_q.push_back(mem_addr);
            wdata_q.push_back(mem_wdata);
        end
        if (fft_start) nstart++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_in(input int w);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[127-16*k -: 16] = samp[8*w+k];
        return r;
    endfunction

    function automatic logic [127:0] pack_out(input int w);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[127-32*j -: 32] = rd(4*w+j);
        return r;
    endfunction

    task automatic send_word(input logic [127:0] w);
        @(negedge clk);
        rx_word = w;
        load = 1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        load = 0;
        repeat (12 + $urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic check_writes(input int n);
        chk("nwrites", 128'(waddr_q.size()), 128'(n));
        for (int i = 0; i < n && i < waddr_q.size(); i++) begin
            chk($sformatf("waddr%0d", i), 128'(waddr_q[i]), 128'(i));
            chk($sformatf("wdata%0d", i), 128'(wdata_q[i]), 128'(samp[i]));
        end
        waddr_q.delete();
        wdata_q.delete();
    endtask

    task automatic fft_pulse();
        @(negedge clk);
        fft_done = 1;
        @(negedge clk);
        fft_done = 0;
    endtask

    task automatic present(input int w);
        int t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("done_up%0d", w), 128'(done), 128'(1));
        chk($sformatf("tx%0d", w), tx_word, pack_out(w));
        rx_word = {$urandom, $urandom, $urandom, $urandom};
        load = 1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        chk($sformatf("done_hold%0d", w), 128'(done), 128'(1));
        load = 0;
        @(negedge clk);
        chk($sformatf("done_e1_%0d", w), 128'(done), 128'(1));
        @(negedge clk);
        chk($sformatf("done_e2_%0d", w), 128'(done), 128'(1));
        @(negedge clk);
        chk($sformatf("done_drop%0d", w), 128'(done), 128'(0));
        chk($sformatf("tx_keep%0d", w), tx_word, pack_out(w));
    endtask

    initial begin
        // reset with load toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            load = ~load;
            if (i % 2 == 1) begin
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_done", 128'(done), 128'(0));
                chk("rst_we", 128'(mem_we), 128'(0));
                chk("rst_start", 128'(fft_start), 128'(0));
                chk("rst_addr", 128'(mem_addr), 128'(0));
                chk("rst_wdata", 128'(mem_wdata), 128'(0));
                chk("rst_tx", tx_word, 128'(0));
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
                chk("rst_ovr", 128'(overrun), 128'(0));
`endif
            end
        end
        load = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (4) @(negedge clk);

        // fft_done in COLLECT is ignored
        fft_done = 1;
        repeat (4) @(negedge clk);
        fft_done = 0;
        repeat (6) @(negedge clk);
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_start", 128'(nstart), 128'(0));
        chk("idle_done", 128'(done), 128'(0));
        check_writes(0);

        // frame 1: sample i has value i
        for (int i = 0; i < 32; i++) samp[i] = 16'(i);
        for (int w = 0; w < 4; w++) begin
            send_word(pack_in(w));
            if (w < 3) chk($sformatf("start_early%0d", w), 128'(nstart), 128'(0));
        end
        chk("start_once", 128'(nstart), 128'(1));
        chk("wait_busy", 128'(busy), 128'(1));
        check_writes(32);

        // load edge in WAIT_FFT is dropped
        send_word({$urandom, $urandom, $urandom, $urandom});
        check_writes(0);
        chk("ovr_busy", 128'(busy), 128'(1));
        chk("ovr_done", 128'(done), 128'(0));
        chk("ovr_start", 128'(nstart), 128'(1));
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
        chk("ovr_flag", 128'(overrun), 128'(1));
`endif

        fft_pulse();
        for (int w = 0; w < 8; w++) present(w);
        chk("frame_end_busy", 128'(busy), 128'(0));
        chk("frame_end_start", 128'(nstart), 128'(1));
        check_writes(0);

        // frame 2 with random samples, reset during READ of word 3
        for (int i = 0; i < 32; i++) samp[i] = 16'($urandom);
        for (int w = 0; w < 4; w++) send_word(pack_in(w));
        check_writes(32);
        chk("start_f2", 128'(nstart), 128'(2));
        fft_pulse();
        for (int w = 0; w < 3; w++) present(w);
        #2 reset_n = 0;
        #1;
        chk("mid_done", 128'(done), 128'(0));
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_tx", tx_word, 128'(0));
        chk("mid_we", 128'(mem_we), 128'(0));
        chk("mid_addr", 128'(mem_addr), 128'(0));
`ifdef FFT_FRAME_CTRL_OVERRUN_EN
        chk("mid_ovr", 128'(overrun), 128'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 8; i++) samp[i] = 16'($urandom);
        send_word(pack_in(0));
        check_writes(8);
        chk("post_busy", 128'(busy), 128'(0));
        chk("post_start", 128'(nstart), 128'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
